// File: rtl/logic_sweep_controller.sv
// Exhaustive 16-vector sweep of a 4-input logic function: drives A..D,
// samples F after a settle delay and records mismatches against A&(B|C|~D).
`timescale 1ns/1ps
module logic_sweep_controller #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        f_in,
    output logic        a_out,
    output logic        b_out,
    output logic        c_out,
    output logic        d_out,
    output logic [3:0]  case_idx,
    output logic        busy,
    output logic        done,
    output logic [4:0]  err_count,
    output logic [15:0] fail_vec,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       expected_f;

    assign expected_f = case_idx[3] & (case_idx[2] | case_idx[1] | ~case_idx[0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            case_idx   <= '0;
            settle_cnt <= '0;
            {a_out, b_out, c_out, d_out} <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            pass       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    {a_out, b_out, c_out, d_out} <= '0;
                    if (start) begin
                        case_idx   <= '0;
                        settle_cnt <= '0;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (f_in != expected_f) begin
                        fail_vec[case_idx] <= 1'b1;
                        err_count          <= err_count + 5'd1;
                    end
                    if (case_idx != 4'd15) begin
                        case_idx   <= case_idx + 4'd1;
                        settle_cnt <= '0;
                        {a_out, b_out, c_out, d_out} <= case_idx + 4'd1;
                        state      <= DRIVE;
                    end else begin
                        // case_idx stays at 15; the function inputs are released
                        {a_out, b_out, c_out, d_out} <= '0;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    pass  <= (err_count == 5'd0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_sweep_controller.sv
// Bench for logic_sweep_controller: directed and randomized response tables
// checked against a table-level model of the sweep.
`timescale 1ns/1ps
module tb_logic_sweep_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, start3;
    logic [15:0] rtab1, rtab3;

    logic a1, b1, c1, d1, busy1, done1, pass1, f1;
    logic [3:0] idx1;
    logic [4:0] err1;
    logic [15:0] fv1;

    logic a3, b3, c3, d3, busy3, done3, pass3, f3;
    logic [3:0] idx3;
    logic [4:0] err3;
    logic [15:0] fv3;

    assign f1 = rtab1[{a1, b1, c1, d1}];
    assign f3 = rtab3[{a3, b3, c3, d3}];

    logic_sweep_controller dut (
        .clk(clk), .reset(reset), .start(start), .f_in(f1),
        .a_out(a1), .b_out(b1), .c_out(c1), .d_out(d1),
        .case_idx(idx1), .busy(busy1), .done(done1),
        .err_count(err1), .fail_vec(fv1), .pass(pass1)
    );

    logic_sweep_controller #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .f_in(f3),
        .a_out(a3), .b_out(b3), .c_out(c3), .d_out(d3),
        .case_idx(idx3), .busy(busy3), .done(done3),
        .err_count(err3), .fail_vec(fv3), .pass(pass3)
    );

    bit          cur;
    logic [3:0]  o_vec, o_idx;
    logic        o_busy, o_done, o_pass;
    logic [4:0]  o_err;
    logic [15:0] o_fv;

    always_comb begin
        if (cur) begin
            o_vec = {a3, b3, c3, d3}; o_idx = idx3; o_busy = busy3; o_done = done3;
            o_pass = pass3; o_err = err3; o_fv = fv3;
        end else begin
            o_vec = {a1, b1, c1, d1}; o_idx = idx1; o_busy = busy1; o_done = done1;
            o_pass = pass1; o_err = err1; o_fv = fv1;
        end
    end

    int unsigned nchk = 0;
    int unsigned npass = 0;
    logic [15:0] golden;

    // Correct function output per vector: 1 for {8,10,11,12,13,14,15}
    function automatic logic [15:0] golden_tab();
        logic [15:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) t[i] = (i == 8) || (i >= 10);
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic kick(input bit sel);
        @(negedge clk);
        if (sel) start3 = 1'b1; else start = 1'b1;
    endtask

    // Entered at a negedge with start asserted; returns at the negedge where done is seen.
    task automatic run_sweep(input bit sel, input int unsigned s, input bit hold, input logic [15:0] tab);
        int unsigned n;
        int unsigned e;
        bit seen;
        logic [15:0] efv;
        n = 16 * (s + 1);
        efv = tab ^ golden;
        seen = 1'b0;
        @(posedge clk);
        if (!hold) begin
            #1;
            if (sel) start3 = 1'b0; else start = 1'b0;
        end
        e = 0;
        while (!seen && e <= n + 5) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
            end else begin
                if (e == 0) begin
                    chk("cleared_err", o_err, 0);
                    chk("cleared_fail", o_fv, 0);
                    chk("cleared_pass", o_pass, 0);
                end
                if (e < n) begin
                    chk("busy_sweep", o_busy, 1);
                    chk("vector", o_vec, e / (s + 1));
                    chk("case_idx", o_idx, e / (s + 1));
                end else begin
                    chk("busy_done_state", o_busy, 0);
                end
                @(posedge clk);
                e++;
            end
        end
        chk("done_seen", seen, 1);
        chk("latency", e, n + 1);
        chk("err_count", o_err, $countones(efv));
        chk("fail_vec", o_fv, efv);
        chk("pass", o_pass, (efv == 16'h0000) ? 1 : 0);
        chk("busy_at_done", o_busy, 0);
    endtask

    task automatic check_idle(input logic [15:0] tab);
        logic [15:0] efv;
        efv = tab ^ golden;
        repeat (3) @(negedge clk);
        chk("done_one_cycle", o_done, 0);
        chk("idle_busy", o_busy, 0);
        chk("idle_vector", o_vec, 0);
        chk("held_err", o_err, $countones(efv));
        chk("held_fail", o_fv, efv);
        chk("held_pass", o_pass, (efv == 16'h0000) ? 1 : 0);
    endtask

    task automatic check_cleared1(input string tag);
        chk({tag, "_idx"}, idx1, 0);
        chk({tag, "_vec"}, {a1, b1, c1, d1}, 0);
        chk({tag, "_busy"}, busy1, 0);
        chk({tag, "_done"}, done1, 0);
        chk({tag, "_err"}, err1, 0);
        chk({tag, "_fail"}, fv1, 0);
        chk({tag, "_pass"}, pass1, 0);
    endtask

    initial begin
        int unsigned ndone;
        logic [15:0] t;
        golden = golden_tab();
        cur = 1'b0;
        reset = 1'b1; start = 1'b0; start3 = 1'b0;
        rtab1 = golden; rtab3 = golden;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared1("reset");
        chk("reset3_busy", busy3, 0);
        chk("reset3_err", err3, 0);
        reset = 1'b0;

        // correct function, tied 0, tied 1
        rtab1 = golden;    kick(0); run_sweep(0, 1, 0, rtab1); check_idle(rtab1);
        rtab1 = 16'h0000;  kick(0); run_sweep(0, 1, 0, rtab1); check_idle(rtab1);
        rtab1 = 16'hFFFF;  kick(0); run_sweep(0, 1, 0, rtab1); check_idle(rtab1);

        for (int k = 0; k < 4; k++) begin
            t = 16'($urandom);
            rtab1 = t;
            kick(0); run_sweep(0, 1, 0, t); check_idle(t);
        end

        // start held: first sweep fails, restart on the cycle after DONE clears results
        rtab1 = 16'h0000;
        kick(0); run_sweep(0, 1, 1, rtab1);
        rtab1 = golden;
        run_sweep(0, 1, 0, rtab1); check_idle(rtab1);

        // reset ten cycles into a sweep aborts it
        rtab1 = 16'hFFFF;
        kick(0);
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("pre_abort_busy", busy1, 1);
        reset = 1'b1;
        @(negedge clk);
        check_cleared1("abort");
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        chk("no_done_after_abort", ndone, 0);
        rtab1 = golden;
        kick(0); run_sweep(0, 1, 0, rtab1); check_idle(rtab1);

        // reset wins over start
        @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("prio_busy", busy1, 0);
        chk("prio_pass", pass1, 0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("prio_idle", busy1, 0);

        // SETTLE_CYCLES=3 instance
        cur = 1'b1;
        rtab3 = golden;
        kick(1); run_sweep(1, 3, 0, rtab3); check_idle(rtab3);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/logic_sweep_controller.md
LOGIC_SWEEP_CONTROLLER -- requirements
Module: logic_sweep_controller

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, giving the number of cycles each input vector is held before F is sampled (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, a request to begin a full 16-vector sweep.
REQ-005 SHALL have port f_in, input, 1, the F output of the SimpleLogicFunction under control.
REQ-006 SHALL have ports a_out, b_out, c_out and d_out, output, 1 each, driving A, B, C and D of the controlled function.
REQ-007 SHALL have port case_idx, output, 4, the index of the vector currently driven.
REQ-008 SHALL have port busy, output, 1, high while in DRIVE or CHECK.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse marking sweep completion.
REQ-010 SHALL have port err_count, output, 5, the number of mismatching vectors (0..16).
REQ-011 SHALL have port fail_vec, output, 16, where bit i is set if vector i mismatched.
REQ-012 SHALL have port pass, output, 1, high after a completed sweep with err_count==0.

Function
REQ-013 SHALL map vector i to a_out=i[3], b_out=i[2], c_out=i[1] and d_out=i[0].
REQ-014 SHALL compute expected F as A&(B|C|~D), which is 1 for i in {8,10,11,12,13,14,15} and 0 otherwise.
REQ-015 SHALL implement the FSM states IDLE, DRIVE, CHECK and DONE.
REQ-016 SHALL, in IDLE with start=1, load case_idx=0, clear the settle counter, err_count, fail_vec and pass, and move to DRIVE.
REQ-017 SHALL, in IDLE with start=0, remain in IDLE and drive a/b/c/d_out=0.
REQ-018 SHALL remain in DRIVE for exactly SETTLE_CYCLES cycles with the vector held stable, then move to CHECK.
REQ-019 SHALL, in CHECK, sample f_in exactly once and, on mismatch, set fail_vec[case_idx] and increment err_count.
REQ-020 SHALL, in CHECK with case_idx!=15, increment case_idx, reset the settle counter and return to DRIVE.
REQ-021 SHALL, in CHECK with case_idx==15, move to DONE without wrapping case_idx.
REQ-022 SHALL, in DONE, assert done for one cycle, set pass=(err_count==0) including the final CHECK result, and return to IDLE.
REQ-023 SHALL take 16*(SETTLE_CYCLES+1)+1 cycles from the edge accepting start to the edge that asserts done (33 at default).
REQ-024 SHALL accept start only in IDLE and ignore it in DRIVE, CHECK and DONE.
REQ-025 SHALL start a new sweep on the IDLE cycle immediately after DONE if start is held high.
REQ-026 SHALL hold err_count, fail_vec and pass stable from DONE until the next accepted start or reset.
REQ-027 SHALL update err_count with 5-bit arithmetic, so it never overflows because at most 16 increments occur.

Reset
REQ-028 SHALL, when reset=1 at a clock edge, force state=IDLE, case_idx=0, a/b/c/d_out=0, busy=0, done=0, err_count=0, fail_vec=0 and pass=0.
REQ-029 SHALL treat reset asserted mid-sweep as aborting the sweep, with no done pulse and all results cleared.
REQ-030 SHALL give reset priority over start in the same cycle.

Verification
REQ-031 SHALL cover: correct F model on f_in, start pulse -> done 33 cycles later, err_count=0, fail_vec=0x0000, pass=1.
REQ-032 SHALL cover: f_in tied 0 -> err_count=7, fail_vec=0xFD00, pass=0.
REQ-033 SHALL cover: f_in tied 1 -> err_count=9, fail_vec=0x02FF, pass=0.
REQ-034 SHALL cover: reset at cycle 10 of a sweep -> all outputs 0 next cycle, no done; a new start then completes with pass=1.
REQ-035 SHALL cover: start held high -> start ignored during the sweep, back-to-back sweeps, results cleared at the second acceptance.
REQ-036 SHALL cover: SETTLE_CYCLES=3 with the correct model -> done 65 cycles after start, each vector stable for 3 cycles before its CHECK.
